// File: rtl/test_run_controller.sv
// Sequencer for a riscv-tests run: holds the core in reset, releases it, then waits for
// the end-of-test PC (pass/fail from gp) or a cycle timeout. All outputs are registered.
`timescale 1ns/1ps
module test_run_controller #(
    parameter logic [31:0] END_PC       = 32'h44,
    parameter logic [31:0] PASS_GP      = 32'h1,
    parameter int unsigned RESET_CYCLES = 1,
    parameter int unsigned MAX_TICKS    = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] core_pc,
    input  logic [31:0] core_gp,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        passed,
    output logic        timed_out,
    output logic [31:0] result_gp,
    output logic [31:0] cycle_count
);

    typedef enum logic [1:0] {IDLE, HOLD, RUN, FINISHED} state_t;

    localparam logic [31:0] HOLD_INIT = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] LAST_TICK = 32'(MAX_TICKS - 1);
    localparam logic [31:0] TICK_CAP  = 32'(MAX_TICKS);

    state_t      state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] gp_q, gp_d;
    logic        passed_q, passed_d;
    logic        to_q, to_d;
    logic        core_rst_q, core_rst_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            cnt_q      <= '0;
            gp_q       <= '0;
            passed_q   <= 1'b0;
            to_q       <= 1'b0;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            cnt_q      <= cnt_d;
            gp_q       <= gp_d;
            passed_q   <= passed_d;
            to_q       <= to_d;
            core_rst_q <= core_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        gp_d     = gp_q;
        passed_d = passed_q;
        to_d     = to_q;

        // Abort beats start and an end-PC match; it has no effect while already idle.
        if (abort && state_q != IDLE) begin
            state_d  = IDLE;
            cnt_d    = '0;
            gp_d     = '0;
            passed_d = 1'b0;
            to_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE, FINISHED: begin
                    if (start) begin
                        state_d  = HOLD;
                        hold_d   = HOLD_INIT;
                        cnt_d    = '0;
                        gp_d     = '0;
                        passed_d = 1'b0;
                        to_d     = 1'b0;
                    end
                end
                HOLD: begin
                    if (hold_q == '0) begin
                        state_d = RUN;
                    end else begin
                        hold_d = hold_q - 32'd1;
                    end
                end
                RUN: begin
                    if (core_pc == END_PC) begin
                        state_d  = FINISHED;
                        gp_d     = core_gp;
                        passed_d = (core_gp == PASS_GP);
                        to_d     = 1'b0;
                    end else if (cnt_q == LAST_TICK) begin
                        state_d  = FINISHED;
                        gp_d     = core_gp;
                        passed_d = 1'b0;
                        to_d     = 1'b1;
                        cnt_d    = TICK_CAP;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        core_rst_d = (state_d != RUN);
        busy_d     = (state_d == HOLD) || (state_d == RUN);
        done_d     = (state_d == FINISHED);
    end

    assign core_rst    = core_rst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign passed      = passed_q;
    assign timed_out   = to_q;
    assign result_gp   = gp_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_test_run_controller.sv
// Self-checking bench: two controller instances (default and short-timeout/long-hold)
// driven by shared stimulus and compared every cycle against a timestamp-based model.
`timescale 1ns/1ps
module tb_test_run_controller;

    localparam logic [31:0] END_PC = 32'h44;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] pc;
    logic [31:0] gp;

    logic        a_core_rst, a_busy, a_done, a_passed, a_to;
    logic [31:0] a_gp, a_cnt;
    logic        b_core_rst, b_busy, b_done, b_passed, b_to;
    logic [31:0] b_gp, b_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    test_run_controller dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .core_pc(pc), .core_gp(gp),
        .core_rst(a_core_rst), .busy(a_busy), .done(a_done), .passed(a_passed),
        .timed_out(a_to), .result_gp(a_gp), .cycle_count(a_cnt)
    );

    test_run_controller #(.RESET_CYCLES(3), .MAX_TICKS(16)) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .core_pc(pc), .core_gp(gp),
        .core_rst(b_core_rst), .busy(b_busy), .done(b_done), .passed(b_passed),
        .timed_out(b_to), .result_gp(b_gp), .cycle_count(b_cnt)
    );

    // Model: a run is described by the edge index at which the core leaves reset;
    // elapsed RUN cycles are derived from edge timestamps rather than a counter.
    longint      t = 0;
    bit          m_active[2];
    bit          m_fin[2];
    longint      m_run_at[2];
    bit          m_pass[2];
    bit          m_to[2];
    logic [31:0] m_gp[2];
    logic [31:0] m_cnt[2];

    function automatic longint rc_of(input int i);
        return (i == 0) ? 64'd1 : 64'd3;
    endfunction

    function automatic longint mt_of(input int i);
        return (i == 0) ? 64'd5000 : 64'd16;
    endfunction

    task automatic model_clear(input int i);
        m_pass[i] = 1'b0;
        m_to[i]   = 1'b0;
        m_gp[i]   = '0;
        m_cnt[i]  = '0;
    endtask

    task automatic model_edge(input int i);
        longint el;
        if (abort && (m_active[i] || m_fin[i])) begin
            m_active[i] = 1'b0;
            m_fin[i]    = 1'b0;
            model_clear(i);
        end else if (!m_active[i]) begin
            if (start) begin
                m_active[i] = 1'b1;
                m_fin[i]    = 1'b0;
                m_run_at[i] = t + rc_of(i);
                model_clear(i);
            end
        end else if (t > m_run_at[i]) begin
            el = t - m_run_at[i] - 1;
            if (pc == END_PC) begin
                m_active[i] = 1'b0;
                m_fin[i]    = 1'b1;
                m_gp[i]     = gp;
                m_pass[i]   = (gp == 32'h1);
                m_to[i]     = 1'b0;
                m_cnt[i]    = el[31:0];
            end else if (el == mt_of(i) - 1) begin
                m_active[i] = 1'b0;
                m_fin[i]    = 1'b1;
                m_gp[i]     = gp;
                m_pass[i]   = 1'b0;
                m_to[i]     = 1'b1;
                m_cnt[i]    = 32'(mt_of(i));
            end else begin
                m_cnt[i] = 32'(el + 1);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i < 2; i++) begin
                    m_active[i] = 1'b0;
                    m_fin[i]    = 1'b0;
                    model_clear(i);
                end
            end else begin
                t = t + 1;
                for (int i = 0; i < 2; i++) model_edge(i);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_inst(input int i, input string p,
                                input logic crst, input logic bsy, input logic dn,
                                input logic ps, input logic to,
                                input logic [31:0] rg, input logic [31:0] cc);
        logic exp_crst;
        exp_crst = !(m_active[i] && t >= m_run_at[i]);
        chk({p, "core_rst"},    {31'd0, crst}, {31'd0, exp_crst});
        chk({p, "busy"},        {31'd0, bsy},  {31'd0, m_active[i]});
        chk({p, "done"},        {31'd0, dn},   {31'd0, m_fin[i]});
        chk({p, "passed"},      {31'd0, ps},   {31'd0, m_pass[i]});
        chk({p, "timed_out"},   {31'd0, to},   {31'd0, m_to[i]});
        chk({p, "result_gp"},   rg, m_gp[i]);
        chk({p, "cycle_count"}, cc, m_cnt[i]);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en && !rst) begin
                compare_inst(0, "a.", a_core_rst, a_busy, a_done, a_passed, a_to, a_gp, a_cnt);
                compare_inst(1, "b.", b_core_rst, b_busy, b_done, b_passed, b_to, b_gp, b_cnt);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int r;
        rst = 1'b1; start = 1'b0; abort = 1'b0; pc = '0; gp = '0;
        repeat (2) @(negedge clk);
        chk("rst.core_rst", {31'd0, a_core_rst}, 32'd1);
        chk("rst.busy",     {31'd0, a_busy},     32'd0);
        chk("rst.done",     {31'd0, a_done},     32'd0);
        chk("rst.result",   a_gp,  32'd0);
        chk("rst.count",    a_cnt, 32'd0);
        rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);

        // Pass run on a; b times out after 16 RUN cycles meanwhile.
        pulse_start();
        chk("pass.core_rst_hold", {31'd0, a_core_rst}, 32'd1);
        chk("pass.busy",          {31'd0, a_busy},     32'd1);
        @(negedge clk);
        chk("pass.core_rst_rel",  {31'd0, a_core_rst}, 32'd0);
        repeat (100) @(negedge clk);
        pc = END_PC; gp = 32'h1;
        @(negedge clk);
        pc = '0; gp = '0;
        chk("pass.done",     {31'd0, a_done},     32'd1);
        chk("pass.passed",   {31'd0, a_passed},   32'd1);
        chk("pass.timeout",  {31'd0, a_to},       32'd0);
        chk("pass.count",    a_cnt, 32'd100);
        chk("pass.result",   a_gp,  32'd1);
        chk("pass.core_rst", {31'd0, a_core_rst}, 32'd1);
        chk("model.pass_cnt", m_cnt[0], 32'd100);
        chk("tmo.done",      {31'd0, b_done},   32'd1);
        chk("tmo.timed_out", {31'd0, b_to},     32'd1);
        chk("tmo.passed",    {31'd0, b_passed}, 32'd0);
        chk("tmo.count",     b_cnt, 32'd16);
        chk("model.tmo_cnt", m_cnt[1], 32'd16);

        // Rerun from DONE clears results; then a fail run with gp=7.
        pulse_start();
        chk("rerun.passed", {31'd0, a_passed}, 32'd0);
        chk("rerun.result", a_gp, 32'd0);
        chk("rerun.busy",   {31'd0, a_busy}, 32'd1);
        chk("rerun.done",   {31'd0, a_done}, 32'd0);
        repeat (30) @(negedge clk);
        pc = END_PC; gp = 32'h7;
        @(negedge clk);
        pc = '0; gp = '0;
        chk("fail.done",     {31'd0, a_done},   32'd1);
        chk("fail.passed",   {31'd0, a_passed}, 32'd0);
        chk("fail.timeout",  {31'd0, a_to},     32'd0);
        chk("fail.code",     a_gp >> 1, 32'd3);
        chk("fail.count",    a_cnt, 32'd29);

        // Stale end PC during HOLD must not end the run.
        pc = END_PC; gp = 32'h1;
        pulse_start();
        chk("hold.b_rst0", {31'd0, b_core_rst}, 32'd1);
        @(negedge clk);
        chk("hold.b_rst1", {31'd0, b_core_rst}, 32'd1);
        @(negedge clk);
        chk("hold.b_rst2", {31'd0, b_core_rst}, 32'd1);
        chk("hold.a_cnt0", a_cnt, 32'd0);
        chk("hold.a_done", {31'd0, a_done}, 32'd1);
        @(negedge clk);
        chk("hold.b_run",  {31'd0, b_core_rst}, 32'd0);
        chk("hold.b_nodone", {31'd0, b_done}, 32'd0);
        @(negedge clk);
        pc = '0; gp = '0;
        chk("hold.b_done", {31'd0, b_done},   32'd1);
        chk("hold.b_cnt",  b_cnt, 32'd0);
        chk("hold.b_pass", {31'd0, b_passed}, 32'd1);

        // Tie on b: end-PC match on the 16th RUN cycle wins over timeout.
        pulse_start();
        repeat (18) @(negedge clk);
        pc = END_PC; gp = 32'h1;
        @(negedge clk);
        pc = '0; gp = '0;
        chk("tie.passed",  {31'd0, b_passed}, 32'd1);
        chk("tie.timeout", {31'd0, b_to},     32'd0);
        chk("tie.count",   b_cnt, 32'd15);

        // Abort at RUN cycle 10 on a.
        pulse_start();
        repeat (11) @(negedge clk);
        chk("abort.pre_cnt", a_cnt, 32'd10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort.busy", {31'd0, a_busy}, 32'd0);
        chk("abort.done", {31'd0, a_done}, 32'd0);
        chk("abort.cnt",  a_cnt, 32'd0);
        chk("abort.b_busy", {31'd0, b_busy}, 32'd0);

        // Abort outranks start and end-PC match on the same edge.
        pulse_start();
        repeat (3) @(negedge clk);
        abort = 1'b1; start = 1'b1; pc = END_PC; gp = 32'h1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0; pc = '0; gp = '0;
        chk("abort_pri.busy", {31'd0, a_busy}, 32'd0);
        chk("abort_pri.done", {31'd0, a_done}, 32'd0);

        // Asynchronous reset in the middle of a run.
        pulse_start();
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst.a_core_rst", {31'd0, a_core_rst}, 32'd1);
        chk("arst.a_busy",     {31'd0, a_busy},     32'd0);
        chk("arst.b_core_rst", {31'd0, b_core_rst}, 32'd1);
        chk("arst.b_busy",     {31'd0, b_busy},     32'd0);
        chk("arst.a_cnt",      a_cnt, 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;

        // Randomized traffic.
        repeat (3000) begin
            @(negedge clk);
            start = ($urandom_range(0, 19) == 0);
            abort = ($urandom_range(0, 79) == 0);
            pc    = ($urandom_range(0, 24) == 0) ? END_PC : $urandom;
            r     = $urandom_range(0, 2);
            gp    = (r == 0) ? 32'h1 : (r == 1) ? 32'h7 : $urandom;
        end
        start = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
